drive_arbiter: RTL
==================

# drive_arbiter

Sequencing controller that sits between the 3-way track sensor, the ultrasonic ranger (`sonic_top`) and the `motor` block of the line-following car. It debounces the raw track inputs into a steering request and arbitrates that request against obstacle stops. It inserts a stop gap on direct left/right reversals and runs a bounded line-lost search before halting. Its `mode` output drives `motor.mode` directly, replacing the combinational distance/tracker mux in the top level.

## Interface
Parameters:
- `DEBOUNCE`, 16: consecutive identical track samples required to adopt a new request (≥1).
- `STOP_CM`, 30: obstacle entry threshold, cm; stop when `distance < STOP_CM`.
- `RESUME_CM`, 40: obstacle exit threshold, cm; must be ≥ `STOP_CM`.
- `RESUME_HOLD`, 1_000_000: consecutive cycles with `distance >= RESUME_CM` before resuming (10 ms).
- `DEAD`, 100_000: stop-gap length, cycles, on direct left↔right reversal (1 ms).
- `LOST_TIMEOUT`, 50_000_000: maximum search cycles after losing the line (0.5 s).

Ports:
- `clk`, in, 1: 100 MHz system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `left_track` / `mid_track` / `right_track`, in, 1 each: 1 = sensor over black line.
- `distance`, in, 20: range in cm from `sonic_top`.
- `mode`, out, 2: motor command. 10 = forward, 01 = right, 11 = left, 00 = stop.
- `obstacle`, out, 1: high while in OBST.
- `lost`, out, 1: high while in HALT.
- `state`, out, 3: debug encoding. RUN=0, DEAD=1, OBST=2, SEARCH=3, HALT=4.

## Operation
- Raw request decode, in priority order:
  - `left_track` → LEFT.
  - else `right_track` → RIGHT.
  - else `mid_track` → FWD.
  - else NONE.
- Debounce:
  - A candidate register and a counter track the raw request.
  - A raw value differing from the candidate loads the candidate and clears the counter.
  - After `DEBOUNCE` consecutive equal samples, `stable_req` takes the candidate.
- `last_turn` records the most recent `stable_req` that was LEFT or RIGHT. It resets to LEFT.
- Obstacle has highest priority. In any state, `distance < STOP_CM` → OBST with `mode=00`, and the hold counter clears.
- OBST:
  - Each cycle with `distance >= RESUME_CM` increments the hold counter.
  - Any other cycle clears it; this includes distances in the hysteresis band.
  - When the counter reaches `RESUME_HOLD`:
    - if `stable_req` ≠ NONE → RUN;
    - else → SEARCH with a fresh timer.
- RUN outputs the `mode` mapping of `stable_req`:
  - `stable_req` changes LEFT→RIGHT or RIGHT→LEFT → DEAD, `mode=00`, counter cleared.
  - `stable_req` becomes NONE → SEARCH, `mode=last_turn`, timer cleared.
- DEAD holds `mode=00` for `DEAD` cycles, then → RUN with the current `stable_req`. If `stable_req` is NONE at that point → SEARCH.
- SEARCH:
  - `mode=last_turn`.
  - `stable_req` ≠ NONE → RUN; no dead gap is inserted.
  - Timer reaches `LOST_TIMEOUT` → HALT.
- HALT: `mode=00`, `lost=1`. Leaves to RUN when `stable_req` ≠ NONE.
- `distance == 0` (no echo yet) counts as an obstacle; this is the fail-safe.
- Counters are 32-bit and saturate; they never wrap.

## Timing
- Reset values: state HALT, `mode=00`, `obstacle=0`, `lost=1`, `stable_req=NONE`, `last_turn=LEFT`, all counters 0.
- `state`, `mode`, `obstacle` and `lost` are registered and all update on the same edge as the state transition. No output glitches.
- Track inputs are used unsynchronised; they come from registered sensor logic.
- Latency, raw track change → `stable_req`: `DEBOUNCE` cycles.
- Latency, `stable_req` → `mode`: 1 further cycle.
- Latency, `distance` crossing below `STOP_CM` → `mode=00`: 1 cycle.
- Simultaneous events in one cycle: obstacle beats reversal, lost and timeout. Reversal beats NONE only if both occur; they cannot, since `stable_req` is single-valued.
- Obstacle during DEAD or SEARCH aborts that state. The DEAD/search timers restart on the next entry.
- `rst` asserted mid-operation forces the reset values on the next edge, regardless of state.

## Test plan
Bench parameters for all scenarios: `DEBOUNCE=4`, `DEAD=3`, `RESUME_HOLD=5`, `LOST_TIMEOUT=10`. Default `distance=100` unless stated.
- Reset, then `mid_track=1`: `mode` stays 00 and `lost=1` for 4 cycles. `mode=10`, `state=0` on cycle 5 after the input change.
- In RUN/FWD, `left_track` toggles 1-0-1 on alternate cycles: `mode` stays 10. Then `left_track` is held 1: `mode=11` after 4+1 cycles.
- In RUN/LEFT, inputs switch to `right_track` only:
  - after debounce, `mode=00`, `state=1` for exactly 3 cycles;
  - then `mode=01`.
- In RUN/FWD, `distance=29`: next cycle `mode=00`, `obstacle=1`.
  - Then `distance=35` for 10 cycles: stays OBST.
  - Then `distance=40` for 4 cycles, 39 for 1 cycle, 40 for 5 cycles: resumes `mode=10` exactly after the final 5-cycle run.
- Last turn RIGHT, all tracks 0:
  - `mode=01`, `state=3` for 10 cycles;
  - then `mode=00`, `lost=1`;
  - `mid_track=1` afterwards gives `mode=10` after debounce.
- In SEARCH, assert `rst` for one cycle: next edge `mode=00`, `state=4`, `lost=1`, `last_turn=LEFT`.

Source files
------------

// File: rtl/drive_arbiter.sv
// Steering sequencer for the line-following car: debounces the track sensor into a
// request and arbitrates it against obstacle stops, reversal gaps and line-lost search.
module drive_arbiter #(
  parameter int unsigned DEBOUNCE     = 16,
  parameter int unsigned STOP_CM      = 30,
  parameter int unsigned RESUME_CM    = 40,
  parameter int unsigned RESUME_HOLD  = 1_000_000,
  parameter int unsigned DEAD         = 100_000,
  parameter int unsigned LOST_TIMEOUT = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        left_track,
  input  logic        mid_track,
  input  logic        right_track,
  input  logic [19:0] distance,
  output logic [1:0]  mode,
  output logic        obstacle,
  output logic        lost,
  output logic [2:0]  state
);

  // Requests share the motor mode encoding so RUN can forward them unchanged.
  localparam logic [1:0] REQ_NONE  = 2'b00;
  localparam logic [1:0] REQ_RIGHT = 2'b01;
  localparam logic [1:0] REQ_FWD   = 2'b10;
  localparam logic [1:0] REQ_LEFT  = 2'b11;

  localparam logic [19:0] STOP_D      = 20'(STOP_CM);
  localparam logic [19:0] RESUME_D    = 20'(RESUME_CM);
  localparam logic [32:0] DEB_LIM     = 33'(DEBOUNCE);
  localparam logic [32:0] HOLD_LIM    = 33'(RESUME_HOLD);
  localparam logic [32:0] DEAD_LIM    = 33'(DEAD);
  localparam logic [32:0] TIMEOUT_LIM = 33'(LOST_TIMEOUT);

  typedef enum logic [2:0] {
    S_RUN    = 3'd0,
    S_DEAD   = 3'd1,
    S_OBST   = 3'd2,
    S_SEARCH = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t      r_state;
  logic [1:0]  r_mode;
  logic        r_obstacle;
  logic        r_lost;
  logic [1:0]  r_cand;
  logic [1:0]  r_stable;
  logic [1:0]  r_last_turn;
  logic [31:0] r_deb_cnt;
  logic [31:0] r_hold_cnt;
  logic [31:0] r_dead_cnt;
  logic [31:0] r_search_cnt;

  logic [1:0]  w_raw_req;
  logic        w_deb_adopt;
  logic        w_obst;
  logic        w_clear;
  logic        w_reversal;
  logic        w_hold_done;
  logic        w_dead_done;
  logic        w_search_done;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    w_raw_req = REQ_NONE;
    if (left_track)       w_raw_req = REQ_LEFT;
    else if (right_track) w_raw_req = REQ_RIGHT;
    else if (mid_track)   w_raw_req = REQ_FWD;
  end

  // The counter holds matches seen after the loading sample, so the run length is cnt+2.
  always_comb begin
    w_deb_adopt = 1'b0;
    if (w_raw_req != r_cand) w_deb_adopt = (DEBOUNCE <= 32'd1);
    else                     w_deb_adopt = ({1'b0, r_deb_cnt} + 33'd2 >= DEB_LIM);
  end

  // Zero distance means no echo yet and is treated as blocked.
  assign w_obst        = (distance == 20'd0) || (distance < STOP_D);
  assign w_clear       = (distance >= RESUME_D);
  assign w_reversal    = ((r_mode == REQ_LEFT) && (r_stable == REQ_RIGHT)) ||
                         ((r_mode == REQ_RIGHT) && (r_stable == REQ_LEFT));
  assign w_hold_done   = ({1'b0, r_hold_cnt} + 33'd1 >= HOLD_LIM);
  assign w_dead_done   = ({1'b0, r_dead_cnt} + 33'd1 >= DEAD_LIM);
  assign w_search_done = ({1'b0, r_search_cnt} + 33'd1 >= TIMEOUT_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand      <= REQ_NONE;
      r_deb_cnt   <= '0;
      r_stable    <= REQ_NONE;
      r_last_turn <= REQ_LEFT;
    end else begin
      if (w_raw_req != r_cand) begin
        r_cand    <= w_raw_req;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= sat_inc(r_deb_cnt);
      end
      if (w_deb_adopt) r_stable <= w_raw_req;
      if ((r_stable == REQ_LEFT) || (r_stable == REQ_RIGHT)) r_last_turn <= r_stable;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_HALT;
      r_mode       <= REQ_NONE;
      r_obstacle   <= 1'b0;
      r_lost       <= 1'b1;
      r_hold_cnt   <= '0;
      r_dead_cnt   <= '0;
      r_search_cnt <= '0;
    end else if (w_obst) begin
      r_state    <= S_OBST;
      r_mode     <= REQ_NONE;
      r_obstacle <= 1'b1;
      r_lost     <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_reversal) begin
            r_state    <= S_DEAD;
            r_mode     <= REQ_NONE;
            r_dead_cnt <= '0;
          end else if (r_stable == REQ_NONE) begin
            r_state      <= S_SEARCH;
            r_mode       <= r_last_turn;
            r_search_cnt <= '0;
          end else begin
            r_mode <= r_stable;
          end
        end
        S_DEAD: begin
          if (!w_dead_done) begin
            r_dead_cnt <= sat_inc(r_dead_cnt);
          end else if (r_stable == REQ_NONE) begin
            r_state      <= S_SEARCH;
            r_mode       <= r_last_turn;
            r_search_cnt <= '0;
          end else begin
            r_state <= S_RUN;
            r_mode  <= r_stable;
          end
        end
        S_OBST: begin
          // Hysteresis-band distances break the hold run just like a new obstacle.
          if (!w_clear) begin
            r_hold_cnt <= '0;
          end else if (!w_hold_done) begin
            r_hold_cnt <= sat_inc(r_hold_cnt);
          end else begin
            r_obstacle <= 1'b0;
            if (r_stable != REQ_NONE) begin
              r_state <= S_RUN;
              r_mode  <= r_stable;
            end else begin
              r_state      <= S_SEARCH;
              r_mode       <= r_last_turn;
              r_search_cnt <= '0;
            end
          end
        end
        S_SEARCH: begin
          if (r_stable != REQ_NONE) begin
            r_state <= S_RUN;
            r_mode  <= r_stable;
          end else if (w_search_done) begin
            r_state <= S_HALT;
            r_mode  <= REQ_NONE;
            r_lost  <= 1'b1;
          end else begin
            r_search_cnt <= sat_inc(r_search_cnt);
          end
        end
        S_HALT: begin
          if (r_stable != REQ_NONE) begin
            r_state <= S_RUN;
            r_mode  <= r_stable;
            r_lost  <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_HALT;
          r_mode     <= REQ_NONE;
          r_obstacle <= 1'b0;
          r_lost     <= 1'b1;
        end
      endcase
    end
  end

  assign mode     = r_mode;
  assign obstacle = r_obstacle;
  assign lost     = r_lost;
  assign state    = r_state;

endmodule
